// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the two-player binary-number game:
//   state_e   - turn sequencer states
//   player_e  - player / winner codes (NONE, P1, P2, TIE)
//   LED_*     - fixed board LED patterns
//   LFSR_TAPS - Galois tap mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1_TURN,
        ST_P1_DONE,
        ST_P2_TURN,
        ST_RESULT
    } state_e;

    typedef enum logic [1:0] {
        PL_NONE = 2'd0,
        PL_P1   = 2'd1,
        PL_P2   = 2'd2,
        PL_TIE  = 2'd3
    } player_e;

    localparam logic [7:0] LED_ALL_ON  = 8'hFF;
    localparam logic [7:0] LED_ALL_OFF = 8'h00;
    localparam logic [7:0] LED_P1_WIN  = 8'hF0;
    localparam logic [7:0] LED_P2_WIN  = 8'h0F;
    localparam logic [7:0] LED_TIE     = 8'hFF;

    localparam logic [7:0] LFSR_TAPS   = 8'hB8;

    // LED pattern shown while the result is on display.
    function automatic logic [7:0] winner_led(input player_e w);
        case (w)
            PL_P1:   winner_led = LED_P1_WIN;
            PL_P2:   winner_led = LED_P2_WIN;
            PL_TIE:  winner_led = LED_TIE;
            default: winner_led = LED_ALL_OFF;
        endcase
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// ---------------------------------------------------------------------------
// game_lfsr
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1 (maximal length, 255 states).
//   clk, rst_n : clock, asynchronous active-low reset (loads SEED)
//   en         : advance one step this cycle
//   value      : current LFSR state, never zero
// ---------------------------------------------------------------------------
module game_lfsr
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] value
);

    // An all-zero seed would lock the register up; fall back to 1.
    localparam logic [7:0] SEED_SAFE = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED_SAFE;
        else        lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/game_turn_sequencer.sv
// ---------------------------------------------------------------------------
// game_turn_sequencer
// Top-level controller: mode select, P1 then P2 timed turns, random targets,
// score accumulation and winner declaration; drives the 8 board LEDs.
//   clk, rst_n     : clock, asynchronous active-low reset
//   UP, DOWN       : start/advance and mode-toggle buttons
//   answer_valid   : one-cycle strobe, answer submitted
//   answer_correct : qualifies answer_valid
//   game_mode      : 0 unsigned, 1 two's complement
//   target         : number the active player must convert
//   active_player  : 0 none, 1 P1, 2 P2
//   sec_left       : seconds remaining in the current turn
//   p1_score, p2_score : saturating scores
//   winner         : 0 none, 1 P1, 2 P2, 3 tie (valid in RESULT)
//   Led            : board LEDs
// Build option SEQ_BUTTON_SYNC_EN: when defined, UP/DOWN are raw async levels
// that are synchronised and edge-detected here (3 cycles extra latency);
// otherwise they are taken as synchronous single-cycle pulses.
// ---------------------------------------------------------------------------
module game_turn_sequencer
    import game_pkg::*;
#(
    parameter int         TICKS_PER_SEC = 100_000_000,
    parameter int         TURN_SECONDS  = 30,
    parameter int         SCORE_W       = 5,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               UP,
    input  logic               DOWN,
    input  logic               answer_valid,
    input  logic               answer_correct,
    output logic               game_mode,
    output logic [7:0]         target,
    output logic [1:0]         active_player,
    output logic [5:0]         sec_left,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         winner,
    output logic [7:0]         Led
);

    localparam int                 TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [5:0]         TURN_LOAD = 6'(TURN_SECONDS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    // ---------------- button front end ----------------
    logic up_p, dn_p;

`ifdef SEQ_BUTTON_SYNC_EN
    // bit 0 = UP, bit 1 = DOWN
    logic [1:0] meta_q, meta_d, sync_q, sync_d, prev_q, prev_d, pulse_q, pulse_d;

    always_comb begin
        meta_d  = {DOWN, UP};
        sync_d  = meta_q;
        prev_d  = sync_q;
        pulse_d = sync_q & ~prev_q;  // one pulse per rising edge
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 2'b00;
            sync_q  <= 2'b00;
            prev_q  <= 2'b00;
            pulse_q <= 2'b00;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign up_p = pulse_q[0];
    assign dn_p = pulse_q[1];
`else
    assign up_p = UP;
    assign dn_p = DOWN;
`endif

    // ---------------- random target source ----------------
    logic [7:0] lfsr_val;

    game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .value (lfsr_val)
    );

    // ---------------- sequencer state ----------------
    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [7:0]         target_q, target_d;
    logic [5:0]         sec_q, sec_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    player_e            winner_q, winner_d;

    logic in_p1, in_p2, tick_wrap;

    assign in_p1     = (state_q == ST_P1_TURN);
    assign in_p2     = (state_q == ST_P2_TURN);
    assign tick_wrap = (tick_q == TICK_LAST);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        sec_d    = sec_q;
        tick_d   = tick_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        winner_d = winner_q;

        case (state_q)
            ST_IDLE: begin
                // UP has priority: a simultaneous DOWN does not flip the mode.
                if (up_p) begin
                    state_d  = ST_P1_TURN;
                    p1_d     = '0;
                    p2_d     = '0;
                    target_d = lfsr_val;
                    sec_d    = TURN_LOAD;
                    tick_d   = '0;
                end else if (dn_p) begin
                    mode_d = ~mode_q;
                end
            end

            ST_P1_TURN, ST_P2_TURN: begin
                if (answer_valid) target_d = lfsr_val;
                if (answer_valid && answer_correct) begin
                    if (in_p1) p1_d = (p1_q == SCORE_MAX) ? p1_q : p1_q + SCORE_W'(1);
                    else       p2_d = (p2_q == SCORE_MAX) ? p2_q : p2_q + SCORE_W'(1);
                end
                if (tick_wrap) begin
                    tick_d = '0;
                    sec_d  = sec_q - 6'd1;
                    if (sec_q == 6'd1) begin
                        if (in_p1) begin
                            state_d = ST_P1_DONE;
                        end else begin
                            // Compare post-update scores so an answer in the
                            // expiry cycle counts toward the result.
                            state_d = ST_RESULT;
                            if (p1_d > p2_d)      winner_d = PL_P1;
                            else if (p2_d > p1_d) winner_d = PL_P2;
                            else                  winner_d = PL_TIE;
                        end
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            ST_P1_DONE: begin
                if (up_p) begin
                    state_d  = ST_P2_TURN;
                    target_d = lfsr_val;
                    sec_d    = TURN_LOAD;
                    tick_d   = '0;
                end
            end

            ST_RESULT: begin
                if (up_p) begin
                    state_d  = ST_IDLE;
                    winner_d = PL_NONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            target_q <= 8'h00;
            sec_q    <= 6'd0;
            tick_q   <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            winner_q <= PL_NONE;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            sec_q    <= sec_d;
            tick_q   <= tick_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            winner_q <= winner_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        active_player = PL_NONE;
        Led           = LED_ALL_OFF;
        case (state_q)
            ST_IDLE:    Led = mode_q ? LED_ALL_ON : LED_ALL_OFF;
            ST_P1_TURN: begin active_player = PL_P1; Led = target_q; end
            ST_P2_TURN: begin active_player = PL_P2; Led = target_q; end
            ST_P1_DONE: Led = 8'(p1_q);
            ST_RESULT:  Led = winner_led(winner_q);
            default:    Led = LED_ALL_OFF;
        endcase
    end

    assign game_mode = mode_q;
    assign target    = target_q;
    assign sec_left  = sec_q;
    assign p1_score  = p1_q;
    assign p2_score  = p2_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_game_turn_sequencer.sv
module tb_game_turn_sequencer;

    localparam int TPS = 4;
    localparam int TS  = 3;
    localparam int SW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, UP, DOWN, answer_valid, answer_correct;
    logic          game_mode;
    logic [7:0]    target, Led;
    logic [1:0]    active_player, winner;
    logic [5:0]    sec_left;
    logic [SW-1:0] p1_score, p2_score;

    game_turn_sequencer #(.TICKS_PER_SEC(TPS), .TURN_SECONDS(TS), .SCORE_W(SW), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .UP(UP), .DOWN(DOWN),
        .answer_valid(answer_valid), .answer_correct(answer_correct),
        .game_mode(game_mode), .target(target), .active_player(active_player),
        .sec_left(sec_left), .p1_score(p1_score), .p2_score(p2_score),
        .winner(winner), .Led(Led)
    );

    // Long-turn instance for score saturation (36-cycle turn).
    logic          up_s, av_s;
    logic          s_mode;
    logic [7:0]    s_target, s_led;
    logic [1:0]    s_active, s_winner;
    logic [5:0]    s_sec;
    logic [SW-1:0] s_p1, s_p2;

    game_turn_sequencer #(.TICKS_PER_SEC(TPS), .TURN_SECONDS(9), .SCORE_W(SW), .LFSR_SEED(8'hA5)) u_sat (
        .clk(clk), .rst_n(rst_n), .UP(up_s), .DOWN(1'b0),
        .answer_valid(av_s), .answer_correct(av_s),
        .game_mode(s_mode), .target(s_target), .active_player(s_active),
        .sec_left(s_sec), .p1_score(s_p1), .p2_score(s_p2),
        .winner(s_winner), .Led(s_led)
    );

    // Reference LFSR: right-shift Galois form of x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    // Scoreboard
    string       tag_q[$];
    logic [31:0] val_q[$];
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] cur_tgt;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        vectors++;
        if (val_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic check_reset_vals();
        expect_v("rst_mode", 0);   chk(game_mode);
        expect_v("rst_target", 0); chk(target);
        expect_v("rst_active", 0); chk(active_player);
        expect_v("rst_sec", 0);    chk(sec_left);
        expect_v("rst_p1", 0);     chk(p1_score);
        expect_v("rst_p2", 0);     chk(p2_score);
        expect_v("rst_winner", 0); chk(winner);
        expect_v("rst_led", 0);    chk(Led);
    endtask

    // UP pulse from IDLE or P1_DONE; optional simultaneous DOWN.
    task automatic start_turn(input int pl, input logic with_down, input logic mode);
        UP = 1'b1; DOWN = with_down;
        cur_tgt = m_lfsr;
        expect_v("start_target", cur_tgt);
        tick();
        UP = 1'b0; DOWN = 1'b0;
        chk(target);
        expect_v("start_active", pl); chk(active_player);
        expect_v("start_sec", TS);    chk(sec_left);
        expect_v("start_mode", mode); chk(game_mode);
    endtask

    // 12 turn cycles; k-th bit of masks drives answer_valid/answer_correct.
    task automatic play_turn(input int pl, input logic [11:0] vm, input logic [11:0] cm, input logic mode);
        for (int k = 0; k < 12; k++) begin
            answer_valid = vm[k]; answer_correct = cm[k];
            if (k == 5) begin UP = 1'b1; DOWN = 1'b1; end
            if (vm[k]) begin
                cur_tgt = m_lfsr;
                expect_v("ans_target", cur_tgt);
            end
            tick();
            answer_valid = 1'b0; answer_correct = 1'b0; UP = 1'b0; DOWN = 1'b0;
            if (vm[k]) chk(target);
            if (k == 3) begin
                expect_v("sec_after_1s", 2); chk(sec_left);
                expect_v("led_is_target", cur_tgt); chk(Led);
            end
            if (k == 5) begin
                expect_v("mode_ignores_down", mode); chk(game_mode);
                expect_v("active_ignores_up", pl); chk(active_player);
            end
            if (k == 10) begin
                expect_v("sec_last", 1); chk(sec_left);
                expect_v("active_before_expiry", pl); chk(active_player);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; UP = 1'b0; DOWN = 1'b0; answer_valid = 1'b0; answer_correct = 1'b0;
        up_s = 1'b0; av_s = 1'b0; cur_tgt = 8'h00;
        #12;
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Mode toggles in IDLE
        DOWN = 1'b1; tick(); DOWN = 1'b0;
        expect_v("mode_toggle1", 1); chk(game_mode);
        expect_v("led_mode1", 8'hFF); chk(Led);
        DOWN = 1'b1; tick(); DOWN = 1'b0;
        expect_v("mode_toggle2", 0); chk(game_mode);
        expect_v("led_mode0", 8'h00); chk(Led);

        // Game 1: UP+DOWN together, P1 = 2 (last correct in expiry cycle), P2 = 2
        start_turn(1, 1'b1, 1'b0);
        play_turn(1, 12'b1000_0010_0100, 12'b1000_0000_0100, 1'b0);
        expect_v("p1done_active", 0); chk(active_player);
        expect_v("p1done_sec", 0);    chk(sec_left);
        expect_v("p1_score_g1", 2);   chk(p1_score);
        expect_v("p1done_led", 8'h02); chk(Led);

        start_turn(2, 1'b0, 1'b0);
        expect_v("p1_kept", 2); chk(p1_score);
        expect_v("p2_start", 0); chk(p2_score);
        play_turn(2, 12'h011, 12'h011, 1'b0);
        expect_v("p2_score_g1", 2); chk(p2_score);
        expect_v("winner_tie", 3);  chk(winner);
        expect_v("led_tie", 8'hFF); chk(Led);
        expect_v("result_active", 0); chk(active_player);

        UP = 1'b1; tick(); UP = 1'b0;
        expect_v("idle_mode_g1", 0); chk(game_mode);
        expect_v("idle_led_g1", 8'h00); chk(Led);
        expect_v("scores_retained", 2); chk(p1_score);

        DOWN = 1'b1; tick(); DOWN = 1'b0;
        expect_v("mode_set1", 1); chk(game_mode);

        // Game 2: P1 = 2, P2 = 3 -> P2 wins
        start_turn(1, 1'b0, 1'b1);
        expect_v("p1_cleared", 0); chk(p1_score);
        play_turn(1, 12'h0C0, 12'h0C0, 1'b1);
        expect_v("p1_score_g2", 2); chk(p1_score);
        start_turn(2, 1'b0, 1'b1);
        play_turn(2, 12'h00E, 12'h00E, 1'b1);
        expect_v("p2_score_g2", 3); chk(p2_score);
        expect_v("winner_p2", 2);   chk(winner);
        expect_v("led_p2", 8'h0F);  chk(Led);
        UP = 1'b1; tick(); UP = 1'b0;
        expect_v("idle_mode_kept", 1); chk(game_mode);
        expect_v("idle_led_mode1", 8'hFF); chk(Led);
        expect_v("idle_active", 0); chk(active_player);
        expect_v("p2_retained", 3); chk(p2_score);

        // Game 3: reset in the middle of P2_TURN
        start_turn(1, 1'b0, 1'b1);
        play_turn(1, 12'h000, 12'h000, 1'b1);
        start_turn(2, 1'b0, 1'b1);
        answer_valid = 1'b1; answer_correct = 1'b1; tick();
        answer_valid = 1'b0; answer_correct = 1'b0;
        tick(); tick();
        rst_n = 1'b0; #1;
        check_reset_vals();
        tick();
        rst_n = 1'b1;
        UP = 1'b1; tick(); UP = 1'b0;
        expect_v("reseed_target", 8'hA5); chk(target);
        expect_v("reseed_active", 1); chk(active_player);

        // Saturation on the long-turn instance
        up_s = 1'b1; tick(); up_s = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            av_s = 1'b1;
            expect_v("sat_score", (n > 31) ? 31 : n);
            tick();
            av_s = 1'b0;
            chk(s_p1);
        end
        expect_v("sat_active", 1); chk(s_active);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
